// File: rtl/pp_pkg.sv
// Shared defaults and FSM encoding for the memory dump reader.
package pp_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/dump_skid_fifo.sv
// 2-entry FIFO that absorbs the memory read latency while the consumer stalls.
module dump_skid_fifo #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic [1:0]   o_occ,
  output logic [W-1:0] o_head
);
  logic [W-1:0] r_mem [2];
  logic         r_wr;
  logic         r_rd;
  logic [1:0]   r_occ;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_push_data;
        r_wr        <= ~r_wr;
      end
      if (i_pop)
        r_rd <= ~r_rd;
      r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_occ  = r_occ;
  assign o_head = r_mem[r_rd];
endmodule

// File: rtl/mem_dump_reader.sv
// Streams a contiguous range of memory words out over valid/ready with their addresses.
module mem_dump_reader
  import pp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr
);
  state_e              r_state;
  state_e              w_state_nx;
  logic                w_accept;
  logic [ADDR_W-1:0]   r_base;
  logic [CNT_W:0]      r_count;
  logic [CNT_W:0]      r_issued;
  logic [CNT_W:0]      r_popped;
  logic                r_inflight;
  logic [ADDR_W-1:0]   r_infl_addr;
  logic                r_zero_done;
  logic                w_pop;
  logic                w_issue;
  logic [1:0]          w_occ;
  logic [ADDR_W+DATA_W-1:0] w_head;

  assign w_pop = out_valid & out_ready;

  // Issue only if the buffer can still hold every word already requested.
  assign w_issue = (r_state == RUN) && (r_issued < r_count) &&
                   (({1'b0, w_occ} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop}));

  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && (count != '0)) begin
          w_accept   = 1'b1;
          w_state_nx = RUN;
        end
      end
      RUN: begin
        if (w_pop && ((r_popped + (CNT_W+1)'(1)) == r_count))
          w_state_nx = DONE;
      end
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_count     <= '0;
      r_issued    <= '0;
      r_popped    <= '0;
      r_inflight  <= 1'b0;
      r_infl_addr <= '0;
      r_zero_done <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_zero_done <= (r_state == IDLE) && start && (count == '0);
      r_inflight  <= w_issue;
      if (w_accept) begin
        r_base   <= base_addr;
        r_count  <= {1'b0, count};
        r_issued <= '0;
        r_popped <= '0;
      end
      if (w_issue) begin
        r_infl_addr <= mem_rd_addr;
        r_issued    <= r_issued + (CNT_W+1)'(1);
      end
      if (w_pop)
        r_popped <= r_popped + (CNT_W+1)'(1);
    end
  end

  dump_skid_fifo #(.W(ADDR_W + DATA_W)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (r_inflight),
    .i_push_data ({r_infl_addr, mem_rd_data}),
    .i_pop       (w_pop),
    .o_occ       (w_occ),
    .o_head      (w_head)
  );

  assign busy        = (r_state == RUN);
  assign done        = (r_state == DONE) | r_zero_done;
  assign mem_rd_en   = w_issue;
  assign mem_rd_addr = r_base + ADDR_W'(r_issued);
  assign out_valid   = (w_occ != 2'd0);
  assign out_addr    = w_head[ADDR_W+DATA_W-1:DATA_W];
  assign out_data    = w_head[DATA_W-1:0];
endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: vector table, corner sequences and random dumps vs. a word-list model.
module tb_mem_dump_reader;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] count;
  logic        busy, done, mem_rd_en;
  logic [31:0] mem_rd_addr;
  logic [15:0] mem_rd_data = 16'h0;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic [31:0] out_addr;

  int n_chk = 0;
  int n_pass = 0;

  mem_dump_reader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memf(input logic [31:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  // Synchronous-read memory; garbage when not strobed so stray captures show up.
  always @(posedge clk)
    mem_rd_data <= mem_rd_en ? memf(mem_rd_addr) : 16'hDEAD;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  function automatic logic ready_for(input int mode, input int c);
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    if (mode == 0) return 1'b1;
    if (mode == 1) return pat[c % 6];
    return 1'($urandom % 2);
  endfunction

  // One complete dump: expected stream is base+i (mod 2^32) for i < n, data memf(addr).
  task automatic run_dump(input logic [31:0] b, input logic [15:0] n, input int mode,
                          input int exp_done, input bit inj);
    int issued, popped, first_rd, first_vld, limit;
    bit stalled, fin;
    logic [47:0] held;
    logic [31:0] ea;
    issued = 0; popped = 0; first_rd = -1; first_vld = -1;
    stalled = 0; fin = 0; held = '0;
    limit = 4 * int'(n) + 20;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; count = n; out_ready = ready_for(mode, 0);
    @(negedge clk);
    chk("busy_before_accept", busy, 0);
    for (int c = 1; c <= limit && !fin; c++) begin
      @(posedge clk); #1;
      start = inj && (c == 2);
      if (start) begin base_addr = 32'h100; count = 16'd7; end
      out_ready = ready_for(mode, c);
      @(negedge clk);
      if (mem_rd_en) begin
        if (first_rd < 0) first_rd = c;
        ea = b + 32'(issued);
        chk("rd_addr", mem_rd_addr, ea);
        issued++;
      end
      if (out_valid) begin
        if (first_vld < 0) first_vld = c;
        if (stalled) chk("held_stable", {out_addr, out_data}, held);
      end
      if (out_valid && out_ready) begin
        ea = b + 32'(popped);
        chk("out_addr", out_addr, ea);
        chk("out_data", out_data, memf(ea));
        popped++;
      end
      stalled = out_valid && !out_ready;
      held = {out_addr, out_data};
      chk("outstanding_le2", (issued - popped) <= 2, 1);
      if (done) begin
        fin = 1;
        chk("done_all_popped", popped, n);
        chk("done_busy_low", busy, 0);
        chk("done_reads_issued", issued, n);
        if (exp_done >= 0) chk("done_cycle", c, exp_done);
      end else begin
        chk("busy", busy, n != 16'd0);
      end
    end
    chk("done_seen", fin, 1);
    if (mode == 0 && n != 16'd0) begin
      chk("first_rd_cycle", first_rd, 1);
      chk("first_valid_cycle", first_vld, 3);
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [31:0] base;
    logic [15:0] cnt;
    int          mode;
    int          exp_done;
    bit          inj;
  } vec_t;

  initial begin
    vec_t vecs [6];
    logic [31:0] rb;
    logic [15:0] rn;

    vecs[0] = '{32'h0000_0020, 16'd3, 0, 6, 1'b0};  // basic dump
    vecs[1] = '{32'h0000_0000, 16'd5, 1, -1, 1'b0}; // back-pressure pattern
    vecs[2] = '{32'h0000_0055, 16'd0, 0, 1, 1'b0};  // zero count
    vecs[3] = '{32'hFFFF_FFFE, 16'd4, 0, 7, 1'b0};  // address wrap
    vecs[4] = '{32'h0000_0200, 16'd6, 0, 9, 1'b1};  // start while busy
    vecs[5] = '{32'h0000_0030, 16'd1, 0, 4, 1'b0};  // single word

    reset = 1'b1; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_zero",
        {busy, done, mem_rd_en, mem_rd_addr, out_valid, out_data, out_addr}, '0);
    @(posedge clk); #1; reset = 1'b0;

    foreach (vecs[i])
      run_dump(vecs[i].base, vecs[i].cnt, vecs[i].mode, vecs[i].exp_done, vecs[i].inj);

    // Reset in the middle of a stalled dump, then a fresh one-word dump.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 32'h0; count = 16'd8; out_ready = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1; start = 1'b0;
    end
    @(negedge clk);
    chk("pre_reset_valid", out_valid, 1);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("post_reset_valid", out_valid, 0);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_done", done, 0);
    @(negedge clk);
    chk("post_reset_done_next", done, 0);
    chk("post_reset_valid_next", out_valid, 0);
    run_dump(32'h40, 16'd1, 0, 4, 1'b0);

    for (int k = 0; k < 8; k++) begin
      rb = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 + 32'($urandom % 16)) : 32'($urandom);
      rn = 16'($urandom_range(1, 12));
      run_dump(rb, rn, 2, -1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_dump_reader.md
Name: mem_dump_reader

Overview:
- Read-side companion to the instruction/data memory load port (write_enable_fm / write_addr_fm / write_data_fm).
- On a start command it reads a contiguous range of 16-bit words from a synchronous-read memory port. It streams them out with their addresses over a valid/ready interface.
- Used by benches and debug logic to dump program or data memory after a run, for example to check that memory location 010 holds 1.
- A 2-entry output buffer absorbs the memory's fixed read latency under back-pressure.

Parameters:
- ADDR_W, 32, memory address width; matches write_addr_fm.
- DATA_W, 16, memory word width; matches write_data_fm.
- CNT_W, 16, width of the word-count field.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command; sampled only while idle.
- base_addr  in  ADDR_W  first word address; latched on an accepted start.
- count  in  CNT_W  number of words to read; latched on an accepted start.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse when the dump is complete.
- mem_rd_en  out  1  read strobe to memory.
- mem_rd_addr  out  ADDR_W  read address to memory.
- mem_rd_data  in  DATA_W  read data; valid exactly 1 cycle after mem_rd_en.
- out_valid  out  1  an output word is available.
- out_ready  in  1  the consumer accepts the word.
- out_data  out  DATA_W  memory word.
- out_addr  out  ADDR_W  address the word came from.

Behaviour:
- Reset (synchronous):
  - All outputs are 0.
  - FSM goes to IDLE.
  - The buffer is emptied and the in-flight flag is cleared.
  - mem_rd_data returning in the cycle after reset is discarded.
- IDLE:
  - start=1 with count!=0: latch base_addr and count, clear the issue and pop counters, go to RUN, and busy=1 from the next cycle.
  - start=1 with count=0: no reads. done pulses in the next cycle and the FSM stays in IDLE.
- RUN, read issue:
  - mem_rd_en=1 when issued<count and (occ + inflight - pop) < 2.
    - occ: buffer occupancy, 0..2.
    - inflight: a read was issued in the previous cycle.
    - pop: out_valid & out_ready in this cycle.
  - mem_rd_addr = base + issued. The sum is taken modulo 2^ADDR_W, so 32'hFFFF_FFFF wraps to 0.
  - mem_rd_en=0 when the issue condition is false; mem_rd_addr is then don't-care but held.
- RUN, return path:
  - When inflight=1, {mem_rd_data, issued address} is written into the buffer at the next edge.
  - The buffer never overflows; this is guaranteed by the issue rule.
- Output:
  - out_valid = (occ!=0).
  - out_data and out_addr show the buffer head and are stable while out_valid=1 and out_ready=0.
  - Words are delivered in ascending address order.
  - Simultaneous push and pop in the same cycle is legal.
- Latency and throughput:
  - start is high in cycle 0.
  - The first mem_rd_en is in cycle 1.
  - The first out_valid is in cycle 3.
  - With out_ready held at 1: one word per cycle, no bubbles.
- Completion:
  - When popped==count, go to DONE for one cycle: done=1 and busy=0.
  - Then return to IDLE, so done is high in the cycle after the final handshake.
- start while busy is ignored, with no effect on the latched values.
- Reset mid-run aborts the dump immediately with no done pulse.
- Counters are CNT_W+1 bits wide, so count=16'hFFFF completes correctly.

Decomposition:
- Shared package (pp_pkg) holds:
  - ADDR_W and DATA_W defaults.
  - The FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- Sub-module dump_skid_fifo holds the 2-entry, {addr,data}-wide buffer with push, pop, occ, and head outputs.
- The top level holds the FSM, the counters, and the issue logic.

Test Plan:
- Basic dump:
  - Memory model returns mem[a] = a[15:0] ^ 16'hA5A5.
  - Stimulus: base=32'h20, count=3, out_ready=1.
  - mem_rd_en is high in cycles 1–3 with addresses 20, 21, 22.
  - Outputs in cycles 3–5: (20, A585), (21, A584), (22, A587).
  - done pulses in cycle 6.
- Back-pressure:
  - Stimulus: base=0, count=5, out_ready toggled 1,0,0,1,0,1, and so on.
  - Words 0–4 appear exactly once, in order, each held stable while stalled.
  - There are never more than 2 reads outstanding, counting buffered plus in-flight.
- Zero count:
  - Stimulus: start with count=0.
  - mem_rd_en never asserts, busy stays 0, and done pulses in cycle 1.
- Address wrap:
  - Stimulus: base=32'hFFFF_FFFE, count=4.
  - out_addr sequence is FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001.
- Reset mid-run:
  - Stimulus: count=8, out_ready=0, reset asserted in cycle 4 for 1 cycle.
  - Next cycle: out_valid=0 and busy=0, with no done pulse.
  - A new start (base=0x40, count=1) then yields the single word at 0x40.
- Start while busy:
  - A second start with base=0x100 is issued mid-dump.
  - It is ignored; addresses continue from the original base.
